// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath.
// Provides byte/column/state widths, the field reduction constant,
// the FSM state encodings, the GF(2^8) xtime helper and the bit
// position of a column inside the 128-bit state.
package aes_pkg;

    localparam int BYTE_W   = 8;
    localparam int COL_W    = 32;
    localparam int STATE_W  = 128;
    localparam int NUM_COLS = 4;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t IDLE = 2'd0;
    localparam fsm_state_t BUSY = 2'd1;
    localparam fsm_state_t DONE = 2'd2;

    // Multiply by 02 in GF(2^8): shift left, reduce when bit 7 falls out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // MSB position of column c; column 0 occupies the top 32 bits.
    function automatic logic [6:0] col_msb(input logic [1:0] col);
        return 7'd127 - {col, 5'd0};
    endfunction

endpackage

// File: rtl/aes_mix_columns_seq_if.sv
// Handshake bundle for aes_mix_columns_seq.
//   inValid/inReady/inData/inBypass : upstream state transfer
//   outValid/outReady/outData       : downstream result transfer
// master = upstream/downstream side, slave = the MixColumns unit.
interface aes_mix_columns_seq_if;
    import aes_pkg::*;

    logic               inValid;
    logic               inReady;
    logic [STATE_W-1:0] inData;
    logic               inBypass;
    logic               outValid;
    logic               outReady;
    logic [STATE_W-1:0] outData;

    modport master (
        output inValid, inData, inBypass, outReady,
        input  inReady, outValid, outData
    );

    modport slave (
        input  inValid, inData, inBypass, outReady,
        output inReady, outValid, outData
    );

endinterface

// File: rtl/aes_mix_column_fun.sv
// Combinational forward MixColumns of a single 32-bit column.
//   col_in  : s0..s3, s0 in the top byte
//   col_out : r0..r3, same byte order
// x03 is formed as xtime(s) ^ s, so only xtime logic is needed.
module aes_mix_column_fun
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [BYTE_W-1:0] s  [4];
    logic [BYTE_W-1:0] s2 [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign s[gi]  = col_in[COL_W-1-BYTE_W*gi -: BYTE_W];
            assign s2[gi] = xtime(s[gi]);
        end
    endgenerate

    assign col_out = {
        s2[0] ^ s2[1] ^ s[1]  ^ s[2]  ^ s[3],
        s[0]  ^ s2[1] ^ s2[2] ^ s[2]  ^ s[3],
        s[0]  ^ s[1]  ^ s2[2] ^ s2[3] ^ s[3],
        s2[0] ^ s[0]  ^ s[1]  ^ s[2]  ^ s2[3]
    };

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Column-serial forward AES MixColumns unit.
// Ports:
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : slave side of aes_mix_columns_seq_if (in/out valid-ready,
//          128-bit data, final-round bypass sideband)
// A state is accepted on inValid & inReady, transformed COLS_PER_CYCLE
// columns per clock in place, then held on outData with outValid until
// outReady. Bypassed states take the same number of cycles unchanged.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic                 clk,
    input  logic                 rstN,
    aes_mix_columns_seq_if.slave bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // With 4 columns per cycle the step wraps to 0 and the only group is column 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % NUM_COLS);
    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

    fsm_state_t         fsm_reg,     fsm_next;
    logic [1:0]         col_idx_reg, col_idx_next;
    logic               bypass_reg,  bypass_next;
    logic [STATE_W-1:0] data_reg,    data_next;

    logic               in_ready;
    logic               accept;
    logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];

    // One column engine per lane; lane gi works on column col_idx + gi.
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            assign col_in[gi] = data_reg[col_msb(col_idx_reg + 2'(gi)) -: COL_W];

            aes_mix_column_fun u_fun (
                .col_in  (col_in[gi]),
                .col_out (col_out[gi])
            );
        end
    endgenerate

    // Held low during reset so upstream never sees a ready unit it cannot use.
    assign in_ready = rstN && ((fsm_reg == IDLE) || ((fsm_reg == DONE) && bus.outReady));
    assign accept   = bus.inValid && in_ready;

    always_comb begin
        fsm_next     = fsm_reg;
        col_idx_next = col_idx_reg;
        bypass_next  = bypass_reg;
        data_next    = data_reg;

        case (fsm_reg)
            IDLE: ;
            BUSY: begin
                if (!bypass_reg) begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        data_next[col_msb(col_idx_reg + 2'(i)) -: COL_W] = col_out[i];
                    end
                end
                col_idx_next = col_idx_reg + COL_STEP;
                if (col_idx_reg == LAST_COL) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase

        // Accept overrides the DONE->IDLE path so consume and load share a cycle.
        if (accept) begin
            fsm_next     = BUSY;
            col_idx_next = 2'd0;
            bypass_next  = bus.inBypass;
            data_next    = bus.inData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fsm_reg     <= IDLE;
            col_idx_reg <= 2'd0;
            bypass_reg  <= 1'b0;
            data_reg    <= '0;
        end else begin
            fsm_reg     <= fsm_next;
            col_idx_reg <= col_idx_next;
            bypass_reg  <= bypass_next;
            data_reg    <= data_next;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = (fsm_reg == DONE);
    assign bus.outData  = data_reg;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
module tb_aes_mix_columns_seq;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    aes_mix_columns_seq_if bus1 ();
    aes_mix_columns_seq_if bus2 ();
    aes_mix_columns_seq_if bus4 ();

    aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rstN(rstN), .bus(bus1));
    aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rstN(rstN), .bus(bus2));
    aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rstN(rstN), .bus(bus4));

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
    localparam logic [127:0] VEC3_IN  = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
    localparam logic [127:0] VEC3_OUT = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    // Reference: generic shift-and-add GF(2^8) multiply with 0x11B reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic byp);
        logic [7:0]   coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [127:0] r = d;
        logic [7:0]   s [4];
        logic [7:0]   acc;
        if (byp) return d;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) s[k] = d[127-8*(4*c+k) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], s[k]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic send1(input logic [127:0] d, input logic byp, output bit ok);
        int n = 0;
        @(negedge clk);
        bus1.inValid  = 1'b1;
        bus1.inData   = d;
        bus1.inBypass = byp;
        while (!bus1.inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus1.inReady;
        @(posedge clk);
        #1;
        bus1.inValid  = 1'b0;
        bus1.inBypass = 1'b0;
    endtask

    task automatic wait1(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus1.outValid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic consume1;
        @(negedge clk);
        bus1.outReady = 1'b1;
        @(posedge clk);
        #1;
        bus1.outReady = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus1.inReady !== 1'b0) begin tests_failed++; $display("FAIL reset_inready: got %b expected 0", bus1.inReady); end
        tests_run++;
        if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid: got %b expected 0", bus1.outValid); end
        tests_run++;
        if (bus1.outData !== 128'h0) begin tests_failed++; $display("FAIL reset_outdata: got %h expected 0", bus1.outData); end
        rstN = 1'b1;
        #1;
        tests_run++;
        if (bus1.inReady !== 1'b1) begin tests_failed++; $display("FAIL release_inready: got %b expected 1", bus1.inReady); end
        tests_run++;
        if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL release_outvalid: got %b expected 0", bus1.outValid); end
        $display("[TB] reset done");
    endtask

    task automatic test_vector(input string name, input logic [127:0] din,
                               input logic byp, input logic [127:0] dexp);
        bit ok;
        int lat;
        send1(din, byp, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL %s_accept: got inReady=0 expected 1", name); end
        wait1(lat);
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
        tests_run++;
        if (bus1.outData !== dexp) begin tests_failed++; $display("FAIL %s_data: got %h expected %h", name, bus1.outData, dexp); end
        $display("[TB] xfer %s byp=%b lat=%0d data=%h", name, byp, lat, bus1.outData);
        consume1();
        tests_run++;
        if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL %s_release: got outValid=%b expected 0", name, bus1.outValid); end
    endtask

    task automatic test_cols_per_cycle;
        int lat2 = -1;
        int lat4 = -1;
        @(negedge clk);
        bus2.inValid = 1'b1; bus2.inData = VEC2_IN; bus2.inBypass = 1'b0;
        bus4.inValid = 1'b1; bus4.inData = VEC2_IN; bus4.inBypass = 1'b0;
        #1;
        tests_run++;
        if (bus2.inReady !== 1'b1 || bus4.inReady !== 1'b1) begin
            tests_failed++; $display("FAIL cols_inready: got %b%b expected 11", bus2.inReady, bus4.inReady);
        end
        @(posedge clk);
        #1;
        bus2.inValid = 1'b0;
        bus4.inValid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (lat2 < 0 && bus2.outValid) lat2 = k;
            if (lat4 < 0 && bus4.outValid) lat4 = k;
        end
        tests_run++;
        if (lat2 != 2) begin tests_failed++; $display("FAIL cols2_latency: got %0d expected 2", lat2); end
        tests_run++;
        if (lat4 != 1) begin tests_failed++; $display("FAIL cols4_latency: got %0d expected 1", lat4); end
        tests_run++;
        if (bus2.outData !== VEC2_OUT) begin tests_failed++; $display("FAIL cols2_data: got %h expected %h", bus2.outData, VEC2_OUT); end
        tests_run++;
        if (bus4.outData !== VEC2_OUT) begin tests_failed++; $display("FAIL cols4_data: got %h expected %h", bus4.outData, VEC2_OUT); end
        $display("[TB] xfer cols2 lat=%0d data=%h", lat2, bus2.outData);
        $display("[TB] xfer cols4 lat=%0d data=%h", lat4, bus4.outData);
        @(negedge clk);
        bus2.outReady = 1'b1;
        bus4.outReady = 1'b1;
        @(posedge clk);
        #1;
        bus2.outReady = 1'b0;
        bus4.outReady = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int lat;
        send1(FIPS_IN, 1'b0, ok);
        wait1(lat);
        tests_run++;
        if (!ok || lat != 4) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus1.outValid !== 1'b1 || bus1.outData !== FIPS_OUT || bus1.inReady !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_hold: got v=%b r=%b d=%h expected v=1 r=0 d=%h",
                         bus1.outValid, bus1.inReady, bus1.outData, FIPS_OUT);
            end
        end
        $display("[TB] xfer b2b_first data=%h", bus1.outData);
        @(negedge clk);
        bus1.outReady = 1'b1;
        bus1.inValid  = 1'b1;
        bus1.inData   = VEC3_IN;
        #1;
        tests_run++;
        if (bus1.inReady !== 1'b1) begin tests_failed++; $display("FAIL b2b_inready: got %b expected 1", bus1.inReady); end
        @(posedge clk);
        #1;
        bus1.outReady = 1'b0;
        bus1.inValid  = 1'b0;
        tests_run++;
        if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL b2b_reload: got outValid=%b expected 0", bus1.outValid); end
        wait1(lat);
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d expected 4", lat); end
        tests_run++;
        if (bus1.outData !== VEC3_OUT) begin tests_failed++; $display("FAIL b2b_second_data: got %h expected %h", bus1.outData, VEC3_OUT); end
        $display("[TB] xfer b2b_second lat=%0d data=%h", lat, bus1.outData);
        consume1();
    endtask

    task automatic test_reset_mid_busy;
        bit ok;
        send1(FIPS_IN, 1'b0, ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        tests_run++;
        if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL midrst_outvalid: got %b expected 0", bus1.outValid); end
        tests_run++;
        if (bus1.outData !== 128'h0) begin tests_failed++; $display("FAIL midrst_outdata: got %h expected 0", bus1.outData); end
        tests_run++;
        if (bus1.inReady !== 1'b0) begin tests_failed++; $display("FAIL midrst_inready: got %b expected 0", bus1.inReady); end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        tests_run++;
        if (bus1.inReady !== 1'b1) begin tests_failed++; $display("FAIL midrst_release_inready: got %b expected 1", bus1.inReady); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus1.outValid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale: got outValid=%b expected 0", bus1.outValid); end
        end
        $display("[TB] reset mid-busy done");
    endtask

    task automatic test_random;
        logic [127:0] q [$];
        logic [127:0] cur;
        logic [127:0] exp_d;
        logic         cur_byp;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        cur     = {$urandom, $urandom, $urandom, $urandom};
        cur_byp = ($urandom_range(0, 3) == 0);
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            bus1.inValid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus1.inData   = cur;
            bus1.inBypass = cur_byp;
            bus1.outReady = ($urandom_range(0, 2) != 0);
            #1;
            if (bus1.outValid && bus1.outReady) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: got unexpected data=%h expected no output", bus1.outData);
                end else begin
                    exp_d = q.pop_front();
                    if (bus1.outData !== exp_d) begin
                        tests_failed++;
                        $display("FAIL rand_data[%0d]: got %h expected %h", got, bus1.outData, exp_d);
                    end
                end
                $display("[TB] xfer rand %0d data=%h", got, bus1.outData);
                got++;
            end
            if (bus1.inValid && bus1.inReady) begin
                q.push_back(ref_mix(cur, cur_byp));
                sent++;
                cur     = {$urandom, $urandom, $urandom, $urandom};
                cur_byp = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        bus1.inValid  = 1'b0;
        bus1.inBypass = 1'b0;
        bus1.outReady = 1'b0;
        tests_run++;
        if (got != 1000 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d results (%0d pending) expected 1000 (0 pending)", got, q.size());
        end
    endtask

    initial begin
        bus1.inValid = 1'b0; bus1.inData = '0; bus1.inBypass = 1'b0; bus1.outReady = 1'b0;
        bus2.inValid = 1'b0; bus2.inData = '0; bus2.inBypass = 1'b0; bus2.outReady = 1'b0;
        bus4.inValid = 1'b0; bus4.inData = '0; bus4.inBypass = 1'b0; bus4.outReady = 1'b0;

        test_reset();
        test_vector("fips", FIPS_IN, 1'b0, FIPS_OUT);
        test_vector("second", VEC2_IN, 1'b0, VEC2_OUT);
        test_cols_per_cycle();
        test_vector("bypass", BYP_IN, 1'b1, BYP_IN);
        test_back_to_back();
        test_reset_mid_busy();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_mix_columns_seq.md
Name: aes_mix_columns_seq

Overview:
Column-serial forward AES MixColumns unit for the encryption datapath. It is the forward counterpart of the InvMixColumns multiply-by-constant functions used in decryption.
- Accepts a 128-bit state over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock using GF(2^8) ×02/×03 logic.
- Presents the result on a held output handshake.
- Sits between ShiftRows and AddRoundKey in the round pipeline. A bypass sideband serves the final round, which skips MixColumns.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2, 4; any other value is a compile-time error.

Ports:
clk  input  1  clock, rising edge
rstN  input  1  asynchronous active-low reset
inValid  input  1  input state valid
inReady  output  1  unit can accept a state this cycle
inData  input  128  input state; byte b = inData[127-8b -: 8]; column c = bytes 4c..4c+3
inBypass  input  1  final round: pass state through unchanged, same latency
outValid  output  1  result valid
outReady  input  1  downstream accepts result
outData  output  128  MixColumns(inData), or inData when bypassed; same byte order

Behaviour:
- FSM states: IDLE, BUSY, DONE. The column counter colIdx is 2 bits.
- Reset (async, rstN=0):
  - state=IDLE, colIdx=0, bypass flag=0, state register=0.
  - Outputs: inReady=0 while in reset, outValid=0, outData=0.
  - Reset mid-operation drops the in-flight state silently; nothing is output after reset release.
- inReady = (state==IDLE) or (state==DONE and outReady). This is combinational from state and outReady only and never depends on inValid.
- Accept occurs when inValid and inReady are both high: register inData and inBypass, set colIdx=0, go to BUSY.
- BUSY: each cycle, replace columns colIdx..colIdx+COLS_PER_CYCLE-1 in the state register.
  - Per column (s0..s3 → r0..r3): r0=2s0^3s1^s2^s3, r1=s0^2s1^3s2^s3, r2=s0^s1^2s2^3s3, r3=3s0^s1^s2^2s3.
  - Multiplication is in GF(2^8) with polynomial 0x11B: ×02 = xtime, ×03 = xtime^x.
  - When bypass is set, columns are left unchanged but counting proceeds identically.
  - colIdx advances by COLS_PER_CYCLE. After the last column, go to DONE.
- Latency: accept at edge N gives outValid=1 after edge N+4/COLS_PER_CYCLE (4, 2 or 1 BUSY cycles).
- DONE: outValid=1 and outData = state register, held stable until outReady.
  - outReady without a new accept: go to IDLE, outValid=0.
  - outReady with inValid in the same cycle: result consumed and new state accepted simultaneously, go directly to BUSY. Throughput is one state per 4/COLS_PER_CYCLE+1 cycles.
- inValid while BUSY is ignored; the upstream holds it because inReady=0.
- outReady while not in DONE has no effect.
- No X propagation: outData is the register value at all times, including during BUSY (partially transformed; consumers must not sample without outValid).

Decomposition:
- Shared package aes_pkg:
  - AES_POLY constant = 8'h1B.
  - Byte/column/state widths (8/32/128).
  - State enum {IDLE, BUSY, DONE}.
  - Function for column extraction index.
- Sub-module aes_mix_column_fun: combinational, 32-bit in to 32-bit out, single-column MixColumns built from ×02 xtime logic. Instantiate COLS_PER_CYCLE copies, with muxes selected by colIdx.

Test Plan:
- Reset then FIPS-197 state: inData=db135345_f20a225c_01010101_c6c6c6c6, COLS_PER_CYCLE=1 → outValid after exactly 4 BUSY cycles, outData=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Second vector: inData=d4d4d4d5_2d26314c_db135345_f20a225c → outData=d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d; repeat with COLS_PER_CYCLE=2 and 4 → same data, latency 2 and 1.
- Bypass: inBypass=1, inData=00112233_44556677_8899aabb_ccddeeff → outData identical to input, same latency as a non-bypassed transform.
- Backpressure/back-to-back: hold outReady=0 for 10 cycles → outData stable, inReady=0; then outReady=1 with inValid=1 → new state accepted in the same cycle, next result correct.
- Async reset mid-BUSY: assert rstN=0 at colIdx=2 → outValid=0 and outData=0 immediately; after release inReady=1 and no stale result appears.
- Random: 1000 random states with random inValid/outReady gaps, checked against a reference model → zero mismatches, no lost or duplicated transfers.
